// File: rtl/matrix_writer_if.sv
// Command channel between game logic and matrix_writer.
// Master = game logic (issues commands), slave = matrix_writer.
interface matrix_writer_if #(
  parameter int CELL_W = 3,
  parameter int RC_W   = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_clear;
  logic [RC_W-1:0]   cmd_row;
  logic [RC_W-1:0]   cmd_col;
  logic [CELL_W-1:0] cmd_value;
  logic              cmd_error;

  modport master (
    output cmd_valid, cmd_clear, cmd_row, cmd_col, cmd_value,
    input  cmd_ready, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_row, cmd_col, cmd_value,
    output cmd_ready, cmd_error
  );
endinterface

// File: rtl/matrix_writer.sv
// Shadow-buffered 5x5 board writer. Commands edit a shadow board; the shadow
// is copied to the displayed board only on the falling edge of vsync, so the
// display never shows a half-updated frame.
module matrix_writer #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int CELL_W = 3,
  parameter int RC_W   = 3
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        vsync,
  matrix_writer_if.slave                              cmd,
  output logic                                        commit_pulse,
  output logic                                        dirty,
  output logic [0:ROWS-1][0:COLS-1][CELL_W-1:0]       matrix_player
);

  localparam int              CELLS    = ROWS * COLS;
  localparam int              IDX_W    = $clog2(CELLS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                                  state, state_nxt;
  logic [IDX_W-1:0]                        idx, idx_nxt;
  logic                                    rdy, err;
  logic [0:ROWS-1][0:COLS-1][CELL_W-1:0]   shadow;
  logic                                    vs_meta, vs_sync, vs_prev, vfall;
  logic                                    accept, wr, in_range, wr_ok, clr_start, clr_done, commit;

  assign cmd.cmd_ready = rdy;
  assign cmd.cmd_error = err;

  // vsync comes from the pixel domain: two-flop sync, then fall detect.
  // Idle level is high so reset values avoid a spurious fall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vfall = vs_prev & ~vs_sync;

  // Command decode, commit qualification and next-state logic.
  always_comb begin
    accept    = cmd.cmd_valid & rdy;
    wr        = accept & ~cmd.cmd_clear;
    in_range  = (cmd.cmd_row < RC_W'(ROWS)) && (cmd.cmd_col < RC_W'(COLS));
    wr_ok     = wr & in_range;
    clr_start = accept & cmd.cmd_clear;
    clr_done  = (state == CLEAR) && (idx == IDX_LAST);
    commit    = vfall & (state == IDLE) & dirty;
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (clr_start) begin
        state_nxt = CLEAR;
        idx_nxt   = '0;
      end
      CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (clr_done) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; ready is registered so it stays low for the first
  // cycle out of reset and exactly tracks the IDLE state afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rdy   <= (state_nxt == IDLE);
    end
  end

  // Shadow board: one cell zeroed per cycle while clearing, else single writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (state == CLEAR && idx == IDX_W'(r * COLS + c))
            shadow[r][c] <= '0;
          else if (wr_ok && cmd.cmd_row == RC_W'(r) && cmd.cmd_col == RC_W'(c))
            shadow[r][c] <= cmd.cmd_value;
        end
      end
    end
  end

  // Commit, dirty tracking and status pulses. A write landing on the commit
  // edge keeps dirty set because the copied shadow predates that write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      matrix_player <= '0;
      dirty         <= 1'b0;
      commit_pulse  <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (commit) matrix_player <= shadow;
      if (wr_ok || clr_done) dirty <= 1'b1;
      else if (commit)       dirty <= 1'b0;
      commit_pulse <= commit;
      err          <= wr & ~in_range;
    end
  end

endmodule

// File: tb/tb_matrix_writer.sv
// Directed bench for matrix_writer: reset, writes, range errors, clear,
// vsync-gated commit, write-on-commit-edge and reset during clear.
module tb_matrix_writer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic vsync = 1'b1;
  logic commit_pulse, dirty;
  logic [0:4][0:4][2:0] matrix_player;
  logic [0:4][0:4][2:0] exp_m;

  int checks = 0;
  int errors = 0;
  int n, pulses;

  matrix_writer_if #(.CELL_W(3), .RC_W(3)) bus ();

  matrix_writer #(.ROWS(5), .COLS(5), .CELL_W(3), .RC_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .vsync        (vsync),
    .cmd          (bus.slave),
    .commit_pulse (commit_pulse),
    .dirty        (dirty),
    .matrix_player(matrix_player)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input int r, input int c, input int v);
    bus.cmd_valid = 1'b1;
    bus.cmd_clear = 1'b0;
    bus.cmd_row   = 3'(r);
    bus.cmd_col   = 3'(c);
    bus.cmd_value = 3'(v);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic clear_cmd();
    bus.cmd_valid = 1'b1;
    bus.cmd_clear = 1'b1;
    bus.cmd_row   = 3'd7;
    bus.cmd_col   = 3'd7;
    bus.cmd_value = 3'd5;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_clear = 1'b0;
  endtask

  // Fall vsync, wait past the commit edge, raise it and let the sync settle.
  task automatic frame();
    vsync = 1'b0;
    repeat (4) tick();
    vsync = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;
    bus.cmd_value = '0;
    exp_m = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_ready", bus.cmd_ready, 1'b0);
    chk("rst_dirty", dirty, 1'b0);
    chk("rst_error", bus.cmd_error, 1'b0);
    chk("rst_pulse", commit_pulse, 1'b0);
    chk("rst_matrix", matrix_player, exp_m);
    reset = 1'b1;
    #1;
    chk("rel_ready_pre", bus.cmd_ready, 1'b0);
    tick();
    chk("rel_ready", bus.cmd_ready, 1'b1);

    // T1: write (1,2)=5 and commit 3 edges after vsync falls
    write(1, 2, 5);
    chk("t1_dirty", dirty, 1'b1);
    chk("t1_err", bus.cmd_error, 1'b0);
    vsync = 1'b0;
    tick(); tick();
    chk("t1_pre_pulse", commit_pulse, 1'b0);
    chk("t1_pre_matrix", matrix_player, exp_m);
    tick();
    exp_m[1][2] = 3'd5;
    chk("t1_pulse", commit_pulse, 1'b1);
    chk("t1_matrix", matrix_player, exp_m);
    chk("t1_cell", matrix_player[1][2], 3'd5);
    chk("t1_dirty_clr", dirty, 1'b0);
    tick();
    chk("t1_pulse_end", commit_pulse, 1'b0);
    vsync = 1'b1;
    repeat (3) tick();

    // T2: write (4,4)=7, no vsync fall for 1000 cycles
    write(4, 4, 7);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      if (commit_pulse) pulses++;
      tick();
    end
    chk("t2_pulses", pulses, 0);
    chk("t2_matrix", matrix_player, exp_m);
    chk("t2_dirty", dirty, 1'b1);
    frame();
    exp_m[4][4] = 3'd7;
    chk("t2_commit", matrix_player, exp_m);
    chk("t2_dirty_clr", dirty, 1'b0);

    // T3: out-of-range writes rejected
    write(5, 0, 3);
    chk("t3_err_row", bus.cmd_error, 1'b1);
    chk("t3_dirty", dirty, 1'b0);
    tick();
    chk("t3_err_end", bus.cmd_error, 1'b0);
    write(0, 7, 1);
    chk("t3_err_col", bus.cmd_error, 1'b1);
    write(0, 4, 0);
    chk("t3_err_edge", bus.cmd_error, 1'b0);
    // (0,4)=0 is valid so dirty is set; commit it, then retry a clean frame
    frame();
    chk("t3_dirty_commit", dirty, 1'b0);
    write(7, 7, 6);
    vsync = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (commit_pulse) pulses++;
      tick();
    end
    chk("t3_no_pulse", pulses, 0);
    chk("t3_matrix", matrix_player, exp_m);
    vsync = 1'b1;
    repeat (3) tick();

    // T4: fill with 2s, commit, clear with vsync falling mid-clear
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        write(r, c, 2);
        exp_m[r][c] = 3'd2;
      end
    frame();
    chk("t4_fill", matrix_player, exp_m);
    clear_cmd();
    n = 0;
    pulses = 0;
    while (!bus.cmd_ready && n < 100) begin
      if (n == 10) vsync = 1'b0;
      if (commit_pulse) pulses++;
      tick();
      n++;
    end
    chk("t4_ready_low", n, 25);
    chk("t4_no_pulse", pulses, 0);
    chk("t4_matrix_kept", matrix_player, exp_m);
    chk("t4_dirty", dirty, 1'b1);
    vsync = 1'b1;
    repeat (3) tick();
    frame();
    exp_m = '0;
    chk("t4_cleared", matrix_player, exp_m);
    chk("t4_dirty_clr", dirty, 1'b0);

    // T5: write (0,0)=3 on the commit edge with (2,2)=1 pending
    write(2, 2, 1);
    vsync = 1'b0;
    tick(); tick();
    write(0, 0, 3);
    chk("t5_pulse", commit_pulse, 1'b1);
    chk("t5_c22", matrix_player[2][2], 3'd1);
    chk("t5_c00", matrix_player[0][0], 3'd0);
    chk("t5_dirty", dirty, 1'b1);
    vsync = 1'b1;
    repeat (3) tick();
    frame();
    chk("t5_c00_next", matrix_player[0][0], 3'd3);
    chk("t5_dirty_clr", dirty, 1'b0);

    // T6: reset asserted at clear cycle 12
    clear_cmd();
    repeat (12) tick();
    reset = 1'b0;
    #1;
    exp_m = '0;
    chk("t6_ready", bus.cmd_ready, 1'b0);
    chk("t6_dirty", dirty, 1'b0);
    chk("t6_pulse", commit_pulse, 1'b0);
    chk("t6_error", bus.cmd_error, 1'b0);
    chk("t6_matrix", matrix_player, exp_m);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_ready_pre", bus.cmd_ready, 1'b0);
    tick();
    chk("t6_ready_rel", bus.cmd_ready, 1'b1);
    // (2,2) lay beyond the partial clear; only reset could have zeroed it
    write(3, 3, 4);
    frame();
    exp_m[3][3] = 3'd4;
    chk("t6_shadow", matrix_player, exp_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
